// File: rtl/aibnd_dcc_pkg.sv
// Shared types and helpers for the aibnd DCC clock-mux select sequencer.
package aibnd_dcc_pkg;

  // Widest mux supported; onehot_of() returns a vector of this width.
  localparam int MAX_SEL = 16;

  // Sequencer phases: gate output, switch select, settle, then ungate.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GATE   = 3'd1,
    SWITCH = 3'd2,
    SETTLE = 3'd3,
    UNGATE = 3'd4
  } seq_state_t;

  // One-hot decode of a select index; callers cast down to their mux width.
  function automatic logic [MAX_SEL-1:0] onehot_of(input logic [3:0] idx);
    logic [MAX_SEL-1:0] one;
    one       = {{(MAX_SEL-1){1'b0}}, 1'b1};
    onehot_of = one << idx;
  endfunction

endpackage

// File: rtl/aibnd_dcc_seq_cnt.sv
// Loadable up-counter with terminal-count compare, shared by the GATE and
// SETTLE phases of the select sequencer.
module aibnd_dcc_seq_cnt
  import aibnd_dcc_pkg::*;
#(
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_tc_val,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  // Count register: clear has priority over increment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_clr) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_en) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == i_tc_val);

endmodule

// File: rtl/aibnd_dcc_mux_seq.sv
// Glitch-safe select sequencer for an N-way DCC clock mux: on a select change
// it gates the mux output, switches the one-hot select, waits for the mux to
// settle and then ungates. All outputs are registered.
module aibnd_dcc_mux_seq
  import aibnd_dcc_pkg::*;
#(
  parameter int NUM_SEL    = 4,
  parameter int SEL_W      = $clog2(NUM_SEL),
  parameter int GATE_CYC   = 2,
  parameter int SETTLE_CYC = 4,
  parameter int RST_SEL    = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  input  logic [SEL_W-1:0]   req_sel,
  output logic               req_ready,
  output logic [NUM_SEL-1:0] sel_onehot,
  output logic [SEL_W-1:0]   sel_cur,
  output logic               clk_gate_en,
  output logic               done,
  output logic               err_range
);

  localparam int CNT_MAX = (GATE_CYC > SETTLE_CYC) ? GATE_CYC : SETTLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [SEL_W-1:0]   RST_IDX = SEL_W'(RST_SEL);
  localparam logic [NUM_SEL-1:0] RST_OH  = NUM_SEL'(onehot_of(4'(RST_SEL)));

  seq_state_t         r_state;
  seq_state_t         w_next;
  logic [SEL_W-1:0]   r_pend;
  logic [SEL_W-1:0]   r_sel;
  logic [NUM_SEL-1:0] r_oh;
  logic               r_gate;
  logic               r_ready;
  logic               r_done;
  logic               r_err;
  logic               r_boot;

  logic               w_accept;
  logic               w_range_ok;
  logic               w_same;
  logic               w_start;
  logic               w_gate_next;
  logic               w_cnt_clr;
  logic               w_cnt_en;
  logic               w_cnt_tc;
  logic [CNT_W-1:0]   w_cnt;
  logic [CNT_W-1:0]   w_tc_val;

  assign w_accept   = req_valid & r_ready & (r_state == IDLE);
  assign w_range_ok = (32'(req_sel) < 32'(NUM_SEL));
  assign w_same     = (req_sel == r_sel);
  assign w_start    = w_accept & w_range_ok & ~w_same;
  assign w_cnt_clr  = w_start | (r_state == SWITCH);
  assign w_cnt_en   = ((r_state == GATE) | (r_state == SETTLE)) & ~w_cnt_tc;

  // Terminal count depends on which timed phase the shared counter serves.
  always_comb begin
    w_tc_val = CNT_W'(SETTLE_CYC - 1);
    if (r_state == GATE) begin
      w_tc_val = CNT_W'(GATE_CYC - 1);
    end else begin
      w_tc_val = CNT_W'(SETTLE_CYC - 1);
    end
  end

  aibnd_dcc_seq_cnt #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_cnt_clr),
    .i_en    (w_cnt_en),
    .i_tc_val(w_tc_val),
    .o_cnt   (w_cnt),
    .o_tc    (w_cnt_tc)
  );

  // Next-state logic and next value of the gate enable.
  always_comb begin
    w_next      = r_state;
    w_gate_next = r_gate;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_next = GATE;
        end else begin
          w_next = IDLE;
        end
      end
      GATE: begin
        w_gate_next = 1'b0;
        if (w_cnt_tc) begin
          w_next = SWITCH;
        end else begin
          w_next = GATE;
        end
      end
      SWITCH: begin
        w_gate_next = 1'b0;
        w_next      = SETTLE;
      end
      SETTLE: begin
        w_gate_next = 1'b0;
        if (w_cnt_tc) begin
          w_next = UNGATE;
        end else begin
          w_next = SETTLE;
        end
      end
      UNGATE: begin
        w_gate_next = 1'b1;
        w_next      = IDLE;
      end
      default: begin
        w_gate_next = 1'b0;
        w_next      = IDLE;
      end
    endcase
  end

  // State register and handshake/status outputs; the reset pass ends in
  // SETTLE->UNGATE, and r_boot keeps that pass from raising done.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SETTLE;
      r_gate  <= 1'b0;
      r_ready <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_boot  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_gate  <= w_gate_next;
      r_ready <= (w_next == IDLE);
      r_done  <= ((r_state == UNGATE) & r_boot) | (w_accept & w_range_ok & w_same);
      r_err   <= w_accept & ~w_range_ok;
      r_boot  <= r_boot | (r_state == UNGATE);
    end
  end

  // Select path: capture the request on accept, apply it only in SWITCH
  // while the mux output is gated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pend <= RST_IDX;
      r_sel  <= RST_IDX;
      r_oh   <= RST_OH;
    end else begin
      if (w_start) begin
        r_pend <= req_sel;
      end else begin
        r_pend <= r_pend;
      end
      if (r_state == SWITCH) begin
        r_sel <= r_pend;
        r_oh  <= NUM_SEL'(onehot_of(4'(r_pend)));
      end else begin
        r_sel <= r_sel;
        r_oh  <= r_oh;
      end
    end
  end

  assign req_ready   = r_ready;
  assign sel_onehot  = r_oh;
  assign sel_cur     = r_sel;
  assign clk_gate_en = r_gate;
  assign done        = r_done;
  assign err_range   = r_err;

endmodule

// File: tb/tb_aibnd_dcc_mux_seq.sv
// Directed bench for aibnd_dcc_mux_seq: a 4-way instance for the sequencing
// cases and a 3-way instance for the out-of-range rejection.
module tb_aibnd_dcc_mux_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       v4, rdy4, ge4, dn4, er4;
  logic [1:0] s4, cur4;
  logic [3:0] oh4;

  logic       v3, rdy3, ge3, dn3, er3;
  logic [1:0] s3, cur3;
  logic [2:0] oh3;

  int n_chk  = 0;
  int n_pass = 0;

  aibnd_dcc_mux_seq #(.NUM_SEL(4)) u_dut4 (
    .clk(clk), .rst(rst), .req_valid(v4), .req_sel(s4), .req_ready(rdy4),
    .sel_onehot(oh4), .sel_cur(cur4), .clk_gate_en(ge4), .done(dn4),
    .err_range(er4)
  );

  aibnd_dcc_mux_seq #(.NUM_SEL(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_sel(s3), .req_ready(rdy3),
    .sel_onehot(oh3), .sel_cur(cur3), .clk_gate_en(ge3), .done(dn3),
    .err_range(er3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    int dn_seen;
    int oh_bad;
    int low_cnt;
    int inv_bad;
    logic [3:0] prev_oh;

    v4 = 1'b0; s4 = 2'd0; v3 = 1'b0; s3 = 2'd0;
    rst = 1'b1;
    repeat (2) tick();

    // Values held during reset
    chk("rst_oh4",   32'(oh4),  32'h1);
    chk("rst_ge4",   32'(ge4),  32'h0);
    chk("rst_rdy4",  32'(rdy4), 32'h0);
    chk("rst_dn4",   32'(dn4),  32'h0);
    chk("rst_cur4",  32'(cur4), 32'h0);
    chk("rst_oh3",   32'(oh3),  32'h1);

    // Release: gate and ready rise on cycle 5, no done pulse
    rst = 1'b0;
    dn_seen = 0; oh_bad = 0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (dn4) dn_seen++;
      if (oh4 != 4'b0001) oh_bad++;
      if (c == 4) begin
        chk("rel_c4_ge",  32'(ge4),  32'h0);
        chk("rel_c4_rdy", 32'(rdy4), 32'h0);
      end
    end
    chk("rel_c5_ge",   32'(ge4),  32'h1);
    chk("rel_c5_rdy",  32'(rdy4), 32'h1);
    chk("rel_c5_rdy3", 32'(rdy3), 32'h1);
    chk("rel_nodone",  32'(dn_seen), 32'h0);
    chk("rel_oh_hold", 32'(oh_bad),  32'h0);

    // Select change 0 -> 2
    s4 = 2'd2; v4 = 1'b1;
    tick();
    v4 = 1'b0;
    low_cnt = 0; dn_seen = 0; inv_bad = 0; prev_oh = oh4;
    for (int j = 0; j <= 8; j++) begin
      if (ge4 == 1'b0) low_cnt++;
      if (ge4 && (oh4 != prev_oh)) inv_bad++;
      prev_oh = oh4;
      if (j < 8 && dn4) dn_seen++;
      if (j == 0) chk("sw_j0_rdy", 32'(rdy4), 32'h0);
      if (j == 2) chk("sw_j2_oh",  32'(oh4),  32'h1);
      if (j == 3) begin
        chk("sw_j3_oh", 32'(oh4), 32'h4);
        chk("sw_j3_ge", 32'(ge4), 32'h0);
      end
      if (j < 8) tick();
    end
    chk("sw_low7",   32'(low_cnt), 32'd7);
    chk("sw_inv",    32'(inv_bad), 32'h0);
    chk("sw_early",  32'(dn_seen), 32'h0);
    chk("sw_done",   32'(dn4),  32'h1);
    chk("sw_cur",    32'(cur4), 32'h2);
    chk("sw_ge",     32'(ge4),  32'h1);
    chk("sw_rdy",    32'(rdy4), 32'h1);

    // Same-select request completes immediately without gating
    s4 = 2'd2; v4 = 1'b1;
    tick();
    v4 = 1'b0;
    chk("same_done", 32'(dn4),  32'h1);
    chk("same_ge",   32'(ge4),  32'h1);
    chk("same_oh",   32'(oh4),  32'h4);
    chk("same_rdy",  32'(rdy4), 32'h1);
    tick();
    chk("same_done_end", 32'(dn4), 32'h0);
    chk("same_ge_end",   32'(ge4), 32'h1);

    // Out-of-range select on the 3-way instance
    s3 = 2'd3; v3 = 1'b1;
    tick();
    v3 = 1'b0;
    chk("rng_err",  32'(er3),  32'h1);
    chk("rng_rdy",  32'(rdy3), 32'h1);
    chk("rng_oh",   32'(oh3),  32'h1);
    chk("rng_cur",  32'(cur3), 32'h0);
    chk("rng_done", 32'(dn3),  32'h0);
    chk("rng_ge",   32'(ge3),  32'h1);
    tick();
    chk("rng_err_end", 32'(er3), 32'h0);

    // Held request with a wandering req_sel: only the accepted value applies
    s4 = 2'd1; v4 = 1'b1;
    tick();
    for (int k = 1; k <= 7; k++) begin
      s4 = 2'(k);
      tick();
    end
    s4 = 2'd3;
    tick();
    chk("hold_done", 32'(dn4),  32'h1);
    chk("hold_cur",  32'(cur4), 32'h1);
    chk("hold_oh",   32'(oh4),  32'h2);
    chk("hold_rdy",  32'(rdy4), 32'h1);
    tick();
    v4 = 1'b0;
    chk("hold_acc2_rdy",  32'(rdy4), 32'h0);
    chk("hold_acc2_done", 32'(dn4),  32'h0);
    repeat (3) tick();
    chk("hold2_oh", 32'(oh4),  32'h8);
    chk("hold2_ge", 32'(ge4),  32'h0);
    chk("hold2_cur", 32'(cur4), 32'h3);

    // Reset asserted in SETTLE
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_oh",  32'(oh4),  32'h1);
    chk("mid_rst_ge",  32'(ge4),  32'h0);
    chk("mid_rst_rdy", 32'(rdy4), 32'h0);
    chk("mid_rst_cur", 32'(cur4), 32'h0);
    tick();
    rst = 1'b0;
    dn_seen = 0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (dn4) dn_seen++;
    end
    chk("rerel_rdy",    32'(rdy4), 32'h1);
    chk("rerel_ge",     32'(ge4),  32'h1);
    chk("rerel_oh",     32'(oh4),  32'h1);
    chk("rerel_nodone", 32'(dn_seen), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
